// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and the
// helper that converts clock frequency and baud rate into cycles per bit.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_e;

    // Rounded integer division so that the bit period is as close as possible
    // to the requested baud rate.
    function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter. Counts clock cycles while the
// transmitter is active and pulses bit_done on the last cycle of each bit.
module uart_bit_timer #(
    parameter int CYCLES_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = 1 + $clog2(CYCLES_PER_BIT);

    logic [CNT_W-1:0] count;

    assign bit_done = enable && (count == CNT_W'(CYCLES_PER_BIT - 1));

    // Cycle counter: cleared at frame start and while idle, wraps every bit period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || !enable) begin
            count <= '0;
        end else if (count == CNT_W'(CYCLES_PER_BIT - 1)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter. A one-word holding register decouples the
// valid/ready handshake from the shifter so frames can run back-to-back.
// Frames are LSB-first: start bit, data bits, optional even parity, stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds one even-parity bit per frame.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int IDX_W          = $clog2(DATA_WIDTH);

    uart_tx_state_e        state;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] shifter;
    logic [IDX_W-1:0]      bit_idx;
    logic                  bit_done;
    logic                  accept;
    logic                  stop_last;
    logic                  load_frame;
    logic [DATA_WIDTH-1:0] load_word;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    assign ready  = !hold_full;
    assign accept = valid && ready;
    assign busy   = (state != IDLE) || hold_full;

    // The final stop cycle also takes a word arriving on that same edge, so
    // such a word bypasses the holding register straight into the shifter.
    assign stop_last  = (state == STOP) && bit_done && (bit_idx == IDX_W'(STOP_BITS - 1));
    assign load_frame = ((state == IDLE) && hold_full) || (stop_last && (hold_full || accept));
    assign load_word  = hold_full ? hold : data_in;

    uart_bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state != IDLE),
        .restart (load_frame),
        .bit_done(bit_done)
    );

    // Holding register: filled on a handshake, emptied when the FSM takes the word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (load_frame) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= data_in;
            hold_full <= 1'b1;
        end
    end

    // Frame sequencer with registered line output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shifter <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (load_frame) begin
                        state   <= START;
                        shifter <= load_word;
                        tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^load_word;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shifter[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state   <= STOP;
                            bit_idx <= '0;
                            tx      <= 1'b1;
`endif
                        end else begin
                            shifter <= shifter >> 1;
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shifter[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state   <= STOP;
                        bit_idx <= '0;
                        tx      <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (stop_last) begin
                        if (load_frame) begin
                            state   <= START;
                            shifter <= load_word;
                            tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^load_word;
`endif
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else if (bit_done) begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
